// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
// mdio_pkg : shared types and field constants for the MDIO responder
// Revision : 1.0
// ============================================================================
package mdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_OP    = 3'd2,
    ST_PHYAD = 3'd3,
    ST_REGAD = 3'd4,
    ST_TA    = 3'd5,
    ST_DATA  = 3'd6,
    ST_SKIP  = 3'd7
  } mdio_state_t;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int PHYAD_W   = 5;
  localparam int REGAD_W   = 5;
  localparam int DATA_W    = 16;
  localparam int SKIP_BITS = 18;

endpackage
`default_nettype wire

// File: rtl/mdio_sync_edge.sv
`default_nettype none
// ============================================================================
// mdio_sync_edge : 2-flop synchronizers, one path with a rising-edge detector
// Revision : 1.0
// ============================================================================
module mdio_sync_edge #(
  parameter int unsigned         LEVEL_W   = 1,
  parameter logic [LEVEL_W-1:0]  LEVEL_RST = '1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               edge_in,
  output logic               edge_rise,
  input  logic [LEVEL_W-1:0] level_in,
  output logic [LEVEL_W-1:0] level_out
);

  logic               edge_s1;
  logic               edge_s2;
  logic               edge_prev;
  logic [LEVEL_W-1:0] lvl_s1;
  logic [LEVEL_W-1:0] lvl_s2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_s1   <= 1'b0;
      edge_s2   <= 1'b0;
      edge_prev <= 1'b0;
      lvl_s1    <= LEVEL_RST;
      lvl_s2    <= LEVEL_RST;
    end else begin
      edge_s1   <= edge_in;
      edge_s2   <= edge_s1;
      edge_prev <= edge_s2;
      lvl_s1    <= level_in;
      lvl_s2    <= lvl_s1;
    end
  end

  assign edge_rise = edge_s2 & ~edge_prev;
  assign level_out = lvl_s2;

endmodule
`default_nettype wire

// File: rtl/mdio_responder.sv
`default_nettype none
// ============================================================================
// mdio_responder : Clause-22 MDIO responder serving a 32 x 16-bit register model
// Revision : 1.0
// ============================================================================
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0CC2,
  parameter logic [31:0] WR_MASK      = 32'hFFFF_FFF1,
  parameter int unsigned MIN_PREAMBLE = 32
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic [15:0] status_in,
  output logic        reg_wr_valid,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        frame_err
);

  // Registers 1..3 are synthesised from status/ID values and never stored.
  localparam logic [31:0] STORE_MASK = WR_MASK & ~32'h0000_000E;
  localparam logic [5:0]  PRE_MAX    = 6'h3F;

  mdio_state_t        state_q, state_d;
  logic [5:0]         pre_cnt_q, pre_cnt_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic               op_hi_q, op_hi_d;
  logic               is_read_q, is_read_d;
  logic [PHYAD_W-1:0] phyad_q, phyad_d;
  logic [REGAD_W-1:0] regad_q, regad_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               out_q, out_d;
  logic               oen_q, oen_d;
  logic               wr_valid_q, wr_valid_d;
  logic               err_q, err_d;
  logic [REGAD_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;

  logic               mdc_rise;
  logic               mdio_s;
  logic [REGAD_W-1:0] rd_addr;
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  reg_q [32];

  mdio_sync_edge #(
    .LEVEL_W   (1),
    .LEVEL_RST (1'b1)
  ) u_sync (
    .clk       (clk_clk),
    .reset_n   (reset_reset_n),
    .edge_in   (mdc),
    .edge_rise (mdc_rise),
    .level_in  (mdio_in),
    .level_out (mdio_s)
  );

  // Address being completed by the current REGAD sample.
  assign rd_addr = {regad_q[REGAD_W-2:0], mdio_s};

  always_comb begin
    rd_data = reg_q[rd_addr];
    if (rd_addr == 5'd1)      rd_data = status_in;
    else if (rd_addr == 5'd2) rd_data = PHY_ID1;
    else if (rd_addr == 5'd3) rd_data = PHY_ID2;
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    op_hi_d    = op_hi_q;
    is_read_d  = is_read_q;
    phyad_d    = phyad_q;
    regad_d    = regad_q;
    shift_d    = shift_q;
    out_d      = out_q;
    oen_d      = oen_q;
    wr_valid_d = 1'b0;
    err_d      = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (mdc_rise) begin
      case (state_q)
        ST_IDLE: begin
          if (mdio_s) begin
            if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 6'd1;
          end else begin
            pre_cnt_d = '0;
            if (32'(pre_cnt_q) >= MIN_PREAMBLE) state_d = ST_START;
          end
        end
        ST_START: begin
          bit_cnt_d = '0;
          if (mdio_s) begin
            state_d = ST_OP;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_OP: begin
          if (bit_cnt_q == 5'd0) begin
            op_hi_d   = mdio_s;
            bit_cnt_d = 5'd1;
          end else begin
            bit_cnt_d = '0;
            case ({op_hi_q, mdio_s})
              OP_READ: begin
                is_read_d = 1'b1;
                state_d   = ST_PHYAD;
              end
              OP_WRITE: begin
                is_read_d = 1'b0;
                state_d   = ST_PHYAD;
              end
              default: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end
            endcase
          end
        end
        ST_PHYAD: begin
          phyad_d = {phyad_q[PHYAD_W-2:0], mdio_s};
          if (bit_cnt_q == 5'(PHYAD_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_REGAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        ST_REGAD: begin
          regad_d = rd_addr;
          if (bit_cnt_q == 5'(REGAD_W - 1)) begin
            bit_cnt_d = '0;
            if (phyad_q != PHY_ADDR) begin
              state_d = ST_SKIP;
            end else begin
              state_d = ST_TA;
              if (is_read_q) shift_d = rd_data;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        ST_TA: begin
          // A read drives the second turnaround bit low; a write just consumes two bits.
          if (is_read_q) begin
            out_d     = 1'b0;
            oen_d     = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end else if (bit_cnt_q == 5'd0) begin
            bit_cnt_d = 5'd1;
          end else begin
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          if (is_read_q) begin
            if (bit_cnt_q == 5'(DATA_W)) begin
              out_d     = 1'b1;
              oen_d     = 1'b1;
              bit_cnt_d = '0;
              state_d   = ST_IDLE;
            end else begin
              out_d     = shift_q[DATA_W-1];
              oen_d     = 1'b0;
              shift_d   = {shift_q[DATA_W-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else begin
            shift_d = {shift_q[DATA_W-2:0], mdio_s};
            if (bit_cnt_q == 5'(DATA_W - 1)) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = regad_q;
              wr_data_d  = {shift_q[DATA_W-2:0], mdio_s};
              bit_cnt_d  = '0;
              state_d    = ST_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        ST_SKIP: begin
          if (bit_cnt_q == 5'(SKIP_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q    <= ST_IDLE;
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      op_hi_q    <= 1'b0;
      is_read_q  <= 1'b0;
      phyad_q    <= '0;
      regad_q    <= '0;
      shift_q    <= '0;
      out_q      <= 1'b1;
      oen_q      <= 1'b1;
      wr_valid_q <= 1'b0;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      op_hi_q    <= op_hi_d;
      is_read_q  <= is_read_d;
      phyad_q    <= phyad_d;
      regad_q    <= regad_d;
      shift_q    <= shift_d;
      out_q      <= out_d;
      oen_q      <= oen_d;
      wr_valid_q <= wr_valid_d;
      err_q      <= err_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_reg
    if (STORE_MASK[i]) begin : g_store
      logic [DATA_W-1:0] q;
      always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) q <= '0;
        else if (wr_valid_d && (wr_addr_d == 5'(i))) q <= wr_data_d;
      end
      assign reg_q[i] = q;
    end else begin : g_none
      assign reg_q[i] = '0;
    end
  end

  assign mdio_out     = out_q;
  assign mdio_oen     = oen_q;
  assign reg_wr_valid = wr_valid_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  assign frame_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_responder.sv
`default_nettype none
// ============================================================================
// tb_mdio_responder : MDIO master bench with a frame-level reference model
// Revision : 1.0
// ============================================================================
module tb_mdio_responder;

  localparam logic [4:0]  PHY  = 5'd1;
  localparam logic [31:0] MASK = 32'hFFFF_FFD1;
  localparam logic [15:0] ID1  = 16'h0141;
  localparam logic [15:0] ID2  = 16'h0CC2;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        mdc    = 1'b1;
  logic        drv    = 1'b1;
  logic [15:0] status = 16'h0000;
  logic        mdio_out, mdio_oen, wr_valid, ferr;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  wire         mdio_line;

  assign mdio_line = mdio_oen ? drv : mdio_out;

  always #5 clk = ~clk;

  mdio_responder #(
    .PHY_ADDR     (PHY),
    .PHY_ID1      (ID1),
    .PHY_ID2      (ID2),
    .WR_MASK      (MASK),
    .MIN_PREAMBLE (32)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .mdc           (mdc),
    .mdio_in       (mdio_line),
    .mdio_out      (mdio_out),
    .mdio_oen      (mdio_oen),
    .status_in     (status),
    .reg_wr_valid  (wr_valid),
    .reg_wr_addr   (wr_addr),
    .reg_wr_data   (wr_data),
    .frame_err     (ferr)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Pulse monitors: count high cycles so both occurrence and width are visible.
  int          wr_cycles  = 0;
  int          err_cycles = 0;
  logic [4:0]  seen_addr  = '0;
  logic [15:0] seen_data  = '0;
  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cycles = wr_cycles + 1;
      seen_addr = wr_addr;
      seen_data = wr_data;
    end
    if (ferr) err_cycles = err_cycles + 1;
  end

  logic [15:0] model_regs [32];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] reg_value(input logic [4:0] a);
    case (a)
      5'd1:    return status;
      5'd2:    return ID1;
      5'd3:    return ID2;
      default: return model_regs[a];
    endcase
  endfunction

  task automatic clock_bit(input logic b, output logic o_oen, output logic o_out);
    drv = b;
    mdc = 1'b0;
    repeat (8) @(negedge clk);
    o_oen = mdio_oen;
    o_out = mdio_out;
    mdc = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic idle_zeros(input int cnt);
    logic a, b;
    for (int i = 0; i < cnt; i++) clock_bit(1'b0, a, b);
  endtask

  // Serialises a frame; r is the index of the last REGAD bit.
  task automatic build(input int pre, input logic [1:0] st, input logic [1:0] op,
                       input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                       output logic [127:0] bits, output int n, output int r);
    bits = '0;
    n = 0;
    for (int i = 0; i < pre; i++) begin bits[n] = 1'b1; n++; end
    for (int i = 1; i >= 0; i--) begin bits[n] = st[i]; n++; end
    for (int i = 1; i >= 0; i--) begin bits[n] = op[i]; n++; end
    for (int i = 4; i >= 0; i--) begin bits[n] = phy[i]; n++; end
    for (int i = 4; i >= 0; i--) begin bits[n] = ra[i]; n++; end
    r = n - 1;
    if (op == 2'b01) begin
      bits[n] = 1'b1; n++;
      bits[n] = 1'b0; n++;
      for (int i = 15; i >= 0; i--) begin bits[n] = wd[i]; n++; end
    end else begin
      for (int i = 0; i < 18; i++) begin bits[n] = 1'b1; n++; end
    end
    n = n + 2;
  endtask

  task automatic do_frame(input string tag, input int pre, input logic [1:0] st,
                          input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] ra, input logic [15:0] wd);
    logic [127:0] bits, exp_oen, exp_out, obs_oen, obs_out;
    logic         o1, o2, resp_read, resp_write, resp_err;
    logic [15:0]  rval;
    int           n, r, wr0, er0;
    resp_read = 1'b0; resp_write = 1'b0; resp_err = 1'b0; rval = '0;
    if (pre >= 32) begin
      if (st != 2'b01 || op == 2'b00 || op == 2'b11) resp_err = 1'b1;
      else if (phy == PHY) begin
        if (op == 2'b10) begin resp_read = 1'b1; rval = reg_value(ra); end
        else resp_write = 1'b1;
      end
    end
    build(pre, st, op, phy, ra, wd, bits, n, r);
    exp_oen = '1;
    exp_out = '0;
    if (resp_read) begin
      for (int i = r + 2; i <= r + 18; i++) exp_oen[i] = 1'b0;
      for (int i = 0; i < 16; i++) exp_out[r + 3 + i] = rval[15 - i];
    end
    obs_oen = '1;
    obs_out = '0;
    wr0 = wr_cycles;
    er0 = err_cycles;
    @(negedge clk);
    for (int j = 0; j < n; j++) begin
      if (j == r + 6) status = ~status;
      clock_bit(bits[j], o1, o2);
      obs_oen[j] = o1;
      obs_out[j] = o2;
    end
    check({tag, " oen"}, obs_oen, exp_oen);
    check({tag, " rdata"}, obs_out & ~exp_oen, exp_out);
    check({tag, " frame_err"}, 128'(err_cycles - er0), 128'(resp_err));
    check({tag, " wr_valid"}, 128'(wr_cycles - wr0), 128'(resp_write));
    if (resp_write) begin
      check({tag, " wr_addr"}, 128'(seen_addr), 128'(ra));
      check({tag, " wr_data"}, 128'(seen_data), 128'(wd));
      if (MASK[ra] && !(ra >= 5'd1 && ra <= 5'd3)) model_regs[ra] = wd;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " oen"},      128'(mdio_oen), 128'(1));
    check({tag, " out"},      128'(mdio_out), 128'(1));
    check({tag, " wr_valid"}, 128'(wr_valid), 128'(0));
    check({tag, " wr_addr"},  128'(wr_addr),  128'(0));
    check({tag, " wr_data"},  128'(wr_data),  128'(0));
    check({tag, " ferr"},     128'(ferr),     128'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] bits;
    logic         o1, o2;
    int           n, r, pre;
    logic [1:0]   st, op;
    logic [4:0]   phy, ra;
    logic [15:0]  wd;

    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle_zeros(2);

    do_frame("read_id1", 32, 2'b01, 2'b10, PHY, 5'd2, 16'h0);
    do_frame("write_r4", 32, 2'b01, 2'b01, PHY, 5'd4, 16'hA5C3);
    do_frame("read_r4", 32, 2'b01, 2'b10, PHY, 5'd4, 16'h0);
    do_frame("write_r5_unstored", 32, 2'b01, 2'b01, PHY, 5'd5, 16'h1234);
    do_frame("read_r5", 32, 2'b01, 2'b10, PHY, 5'd5, 16'h0);
    do_frame("mismatch_phy7", 32, 2'b01, 2'b10, 5'd7, 5'd2, 16'h0);
    do_frame("after_mismatch", 32, 2'b01, 2'b10, PHY, 5'd3, 16'h0);
    status = 16'h7949;
    do_frame("pre31", 31, 2'b01, 2'b10, PHY, 5'd1, 16'h0);
    do_frame("pre32", 32, 2'b01, 2'b10, PHY, 5'd1, 16'h0);
    do_frame("bad_st00", 32, 2'b00, 2'b10, PHY, 5'd2, 16'h0);
    do_frame("bad_op11", 32, 2'b01, 2'b11, PHY, 5'd2, 16'h0);
    do_frame("write_r1_ro", 32, 2'b01, 2'b01, PHY, 5'd1, 16'hFFFF);

    for (int k = 0; k < 24; k++) begin
      pre    = ($urandom_range(0, 3) == 0) ? 31 : 32 + int'($urandom_range(0, 6));
      st     = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
      op     = 2'($urandom_range(0, 3));
      phy    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : PHY;
      ra     = 5'($urandom_range(0, 7));
      wd     = 16'($urandom);
      status = 16'($urandom);
      do_frame("random", pre, st, op, phy, ra, wd);
    end

    do_frame("write_r4_again", 32, 2'b01, 2'b01, PHY, 5'd4, 16'hBEEF);
    build(32, 2'b01, 2'b10, PHY, 5'd4, 16'h0, bits, n, r);
    @(negedge clk);
    for (int j = 0; j <= r + 9; j++) clock_bit(bits[j], o1, o2);
    check("driving_d8", 128'(mdio_oen), 128'(0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    idle_zeros(2);
    do_frame("read_r4_after_reset", 32, 2'b01, 2'b10, PHY, 5'd4, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdio_responder.md
# mdio_responder

Clause-22 MDIO management responder (PHY-side end of the TSE MAC MDIO master). Oversamples MDC/MDIO in the system clock domain, decodes read/write frames addressed to its PHY address, and serves a 32 × 16-bit register model. Supplies ID/status registers and notifies the user logic of every accepted write. Used as an on-chip PHY management model next to the nios_system MAC and as a bench responder.

## Interface
- PHY_ADDR, 5'd0: PHY address the block answers to.
- PHY_ID1, 16'h0141: value returned for register 2.
- PHY_ID2, 16'h0CC2: value returned for register 3.
- WR_MASK, 32'hFFFF_FFF1: bit n = 1 means register n is writable and stored. Registers 1–3 are never stored.
- MIN_PREAMBLE, 32: minimum consecutive 1 bits required before ST.
- clk_clk  in  1  system clock; must be ≥ 8× MDC frequency.
- reset_reset_n  in  1  synchronous, active-low reset.
- mdc  in  1  management clock from the MAC (asynchronous to clk_clk).
- mdio_in  in  1  resolved MDIO line value.
- mdio_out  out  1  data driven onto MDIO.
- mdio_oen  out  1  output enable, active-low (0 = drive).
- status_in  in  16  live value returned for register 1.
- reg_wr_valid  out  1  one-cycle pulse on an accepted write.
- reg_wr_addr  out  5  register address of the write.
- reg_wr_data  out  16  write data.
- frame_err  out  1  one-cycle pulse on a bad ST/OP field.

## Operation
- mdc and mdio_in each pass through a 2-flop synchronizer. A rise on synced mdc gives mdc_rise (1 cycle). MDIO is sampled only on mdc_rise.
- States: IDLE, START, OP, PHYAD, REGAD, TA, DATA, SKIP.
- IDLE counts consecutive sampled 1s with a saturating 6-bit counter. A 0 clears the counter.
  - A 0 seen with count ≥ MIN_PREAMBLE goes to START. That 0 is ST bit 1.
  - A 0 with a shorter count stays in IDLE and raises no error.
- START: sample must be 1, otherwise frame_err and return to IDLE.
- OP: two bits MSB first.
  - 10 = read, 01 = write.
  - 00 or 11 → frame_err, IDLE.
- PHYAD: 5 bits, then REGAD: 5 bits, both MSB first.
- If PHYAD ≠ PHY_ADDR, go to SKIP. SKIP ignores 18 bits, never drives, then returns to IDLE.
- Read, on the mdc_rise that samples REGAD bit 0:
  - latch read data: reg 1 = status_in, reg 2 = PHY_ID1, reg 3 = PHY_ID2, masked register = stored value, otherwise 16'h0000;
  - leave the line released for TA bit 1.
  - Next mdc_rise: drive 0 (TA bit 2).
  - The following 16 mdc_rises each drive the next data bit, D15 first.
  - The mdc_rise after D0's period releases the line (oen = 1) and returns to IDLE.
- Write:
  - TA: two bits consumed; their values are ignored.
  - DATA: 16 bits shifted in MSB first.
  - On the cycle after the last data sample: pulse reg_wr_valid with addr/data. Store the data only if WR_MASK[addr] = 1. Return to IDLE.
  - reg_wr_valid pulses for every address-matched write, whatever the mask says.
- A new frame always needs a fresh preamble. There is no preamble suppression.
- Stored register reset value is 16'h0000.

## Timing
- Reset (reset_reset_n = 0 at a clk_clk edge) gives:
  - state IDLE, counters 0, stored registers 0;
  - mdio_oen = 1, mdio_out = 1;
  - reg_wr_valid = 0, reg_wr_addr = 0, reg_wr_data = 0, frame_err = 0.
- Reset in the middle of a frame releases the line on the next edge.
- Input latency: 2 clk from a pin edge to the synced value. mdc_rise is asserted in the 3rd cycle after the MDC pin rises.
- Output change (mdio_out, mdio_oen) is registered 1 clk after mdc_rise. MDC-rise-to-drive delay is ≤ 4 clk_clk, well inside the 300 ns PHY limit at ≥ 25 MHz clk.
- reg_wr_valid and frame_err are exactly 1 cycle wide.
- reg_wr_addr and reg_wr_data hold their value until the next write.
- A status_in change after the data latch does not affect a read already in progress.

## Structure
- Package mdio_pkg holds:
  - state enum;
  - OP_READ = 2'b10, OP_WRITE = 2'b01;
  - field widths (PHYAD_W = 5, REGAD_W = 5, DATA_W = 16);
  - SKIP_BITS = 18.
- Sub-module mdio_sync_edge: 2-flop synchronizer plus rising-edge detector, instantiated for mdc. The same synchronizer without the detector is used for mdio_in.
- Register file: 32 × 16 flops gated by WR_MASK. Unused entries are optimized away.

## Test plan
- Read ID, PHY_ADDR = 1: 32 preamble 1s, frame 01 10 00001 00010 → oen released for TA1, 0 on TA2, then 0x0141 MSB first, oen = 1 afterwards.
- Write then readback: write reg 4 = 0xA5C3 → reg_wr_valid 1 cycle with addr 4 / data 0xA5C3; a read of reg 4 returns 0xA5C3. Write reg 5 with WR_MASK[5] cleared → pulse seen, readback 0x0000.
- Address mismatch: read to PHYAD 7 with PHY_ADDR = 1 → mdio_oen stays 1 for the whole frame. A following valid frame is answered.
- Short preamble (31 ones) then a valid frame → no response and no frame_err. The same frame with 32 ones → answered.
- Bad frames: ST = 00 → frame_err pulse. OP = 11 → frame_err pulse. oen stays 1 in both cases.
- Reset asserted during data bit D8 of a read → mdio_oen = 1 on the next clk edge, and all outputs take their reset values.
